// File: rtl/corr_acc8_32.sv
// Lag-bin correlator: accumulates cur_in*lag_in into NLAG saturating bins per frame,
// then holds the bins for random-access readout.
//
// state    | meaning
// CLEAR    | zero one bin per cycle; then IDLE, or ACCUM when restarted from HOLD
// IDLE     | waiting for start with nonzero frame_len
// ACCUM    | accepting lag beats and counting bursts
// DRAIN    | two cycles letting the pipeline retire into the bins
// HOLD     | frame complete; bins readable via rd_req
module corr_acc8_32 #(
  parameter int DW   = 8,
  parameter int NLAG = 32,
  parameter int AW   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    start,
  input  logic [15:0]             frame_len,
  input  logic [DW-1:0]           cur_in,
  input  logic [DW-1:0]           lag_in,
  input  logic                    lag_valid,
  input  logic                    lag_first,
  input  logic                    lag_last,
  input  logic                    rd_req,
  input  logic [$clog2(NLAG)-1:0] rd_addr,
  output logic [AW-1:0]           rd_data,
  output logic                    rd_valid,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overflow,
  output logic                    lag_err
);

  localparam int LW = $clog2(NLAG);
  localparam int PW = 2 * DW;
  localparam int SW = ((AW > PW) ? AW : PW) + 1;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] clr_ptr;
  logic          to_accum;
  logic [15:0]   frame_len_q;
  logic [15:0]   burst_cnt;
  logic          drain_cnt;
  logic [LW:0]   lag_idx;

  logic          s1_valid;
  logic [PW-1:0] s1_prod;
  logic [LW-1:0] s1_idx;
  logic          wb_valid;
  logic [LW-1:0] wb_idx;
  logic [AW-1:0] wb_sum;

  logic [AW-1:0] bin_mem [NLAG];

  logic          beat_ok;
  logic          start_ok;
  logic          last_burst;
  logic [LW:0]   idx_next;
  logic [AW-1:0] base;
  logic [SW-1:0] sum_full;
  logic          sat;
  logic [AW-1:0] sum_sat;

  // Index saturates once past the last bin so long bursts keep being dropped.
  always_comb begin
    beat_ok    = (state == ST_ACCUM) && lag_valid && !clr;
    start_ok   = start && (frame_len != 16'd0);
    last_burst = lag_last && ((burst_cnt + 16'd1) == frame_len_q);
    if (lag_first)
      idx_next = '0;
    else if (lag_idx[LW])
      idx_next = lag_idx;
    else
      idx_next = lag_idx + (LW+1)'(1);
  end

  // The pending write-back holds the newest value of its bin until it commits.
  always_comb begin
    base     = (wb_valid && (wb_idx == s1_idx)) ? wb_sum : bin_mem[s1_idx];
    sum_full = SW'(base) + SW'(s1_prod);
    sat      = |sum_full[SW-1:AW];
    sum_sat  = sat ? '1 : sum_full[AW-1:0];
  end

  assign busy = (state == ST_CLEAR) || (state == ST_ACCUM) || (state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_ptr     <= '0;
      to_accum    <= 1'b0;
      frame_len_q <= '0;
      burst_cnt   <= '0;
      drain_cnt   <= 1'b0;
      lag_idx     <= '0;
      s1_valid    <= 1'b0;
      s1_prod     <= '0;
      s1_idx      <= '0;
      wb_valid    <= 1'b0;
      wb_idx      <= '0;
      wb_sum      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      lag_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_valid   <= (state == ST_HOLD) && rd_req;
      if ((state == ST_HOLD) && rd_req)
        rd_data <= bin_mem[rd_addr];

      s1_valid <= 1'b0;
      wb_valid <= s1_valid;
      if (s1_valid) begin
        wb_idx <= s1_idx;
        wb_sum <= sum_sat;
        if (sat)
          overflow <= 1'b1;
      end

      if (beat_ok) begin
        lag_idx <= idx_next;
        if (!idx_next[LW]) begin
          s1_valid <= 1'b1;
          s1_prod  <= PW'(cur_in) * PW'(lag_in);
          s1_idx   <= idx_next[LW-1:0];
        end else begin
          lag_err <= 1'b1;
        end
        if (lag_last)
          burst_cnt <= burst_cnt + 16'd1;
      end

      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + LW'(1);
          if (clr_ptr == LW'(NLAG - 1)) begin
            state    <= to_accum ? ST_ACCUM : ST_IDLE;
            to_accum <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (start_ok) begin
            frame_len_q <= frame_len;
            burst_cnt   <= '0;
            overflow    <= 1'b0;
            lag_err     <= 1'b0;
            state       <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat_ok && last_burst) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 1'b0) begin
            state      <= ST_HOLD;
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (start_ok) begin
            frame_len_q <= frame_len;
            burst_cnt   <= '0;
            overflow    <= 1'b0;
            lag_err     <= 1'b0;
            clr_ptr     <= '0;
            to_accum    <= 1'b1;
            state       <= ST_CLEAR;
          end
        end
        default: begin
          clr_ptr  <= '0;
          to_accum <= 1'b0;
          state    <= ST_CLEAR;
        end
      endcase

      if (clr) begin
        state      <= ST_CLEAR;
        clr_ptr    <= '0;
        to_accum   <= 1'b0;
        s1_valid   <= 1'b0;
        wb_valid   <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      bin_mem[clr_ptr] <= '0;
    else if (wb_valid)
      bin_mem[wb_idx] <= wb_sum;
  end

endmodule

// File: tb/tb_corr_acc8_32.sv
// Directed bench for corr_acc8_32; a second instance with AW=20 exercises saturation.
module tb_corr_acc8_32;

  logic        clk = 1'b0;
  logic        rst_n, clr, start;
  logic [15:0] frame_len;
  logic [7:0]  cur_in, lag_in;
  logic        lag_valid, lag_first, lag_last, rd_req;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid, frame_done, busy, overflow, lag_err;
  logic [19:0] rd_data20;
  logic        rd_valid20, frame_done20, busy20, overflow20, lag_err20;

  logic [63:0] exp_bins [32];
  logic [63:0] exp20 [32];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  corr_acc8_32 dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .frame_len(frame_len),
    .cur_in(cur_in), .lag_in(lag_in), .lag_valid(lag_valid), .lag_first(lag_first),
    .lag_last(lag_last), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_done(frame_done), .busy(busy), .overflow(overflow),
    .lag_err(lag_err)
  );

  corr_acc8_32 #(.AW(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .frame_len(frame_len),
    .cur_in(cur_in), .lag_in(lag_in), .lag_valid(lag_valid), .lag_first(lag_first),
    .lag_last(lag_last), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data20),
    .rd_valid(rd_valid20), .frame_done(frame_done20), .busy(busy20), .overflow(overflow20),
    .lag_err(lag_err20)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    frame_len = len;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [7:0] cur, input bit lag_is_idx,
                            input logic [7:0] lag_const);
    for (int i = 0; i < n; i++) begin
      cur_in    = cur;
      lag_in    = lag_is_idx ? 8'(i) : lag_const;
      lag_first = (i == 0);
      lag_last  = (i == n - 1);
      lag_valid = 1'b1;
      cyc();
    end
    lag_valid = 1'b0;
    lag_first = 1'b0;
    lag_last  = 1'b0;
  endtask

  task automatic single_beats(input int n, input logic [7:0] v);
    cur_in = v;
    lag_in = v;
    lag_first = 1'b1;
    lag_last  = 1'b1;
    lag_valid = 1'b1;
    cyc(n);
    lag_valid = 1'b0;
    lag_first = 1'b0;
    lag_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_done20"}, frame_done20, 1);
    cyc();
    chk({tag, "_done_pulse"}, frame_done, 0);
    chk({tag, "_hold_busy"}, busy, 0);
  endtask

  task automatic read_all(input string tag, input bit with20);
    rd_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      cyc();
      chk($sformatf("%s_v%0d", tag, i), rd_valid, 1);
      chk($sformatf("%s_bin%0d", tag, i), rd_data, exp_bins[i]);
      if (with20)
        chk($sformatf("%s_bin20_%0d", tag, i), rd_data20, exp20[i]);
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; frame_len = '0;
    cur_in = '0; lag_in = '0; lag_valid = 1'b0; lag_first = 1'b0; lag_last = 1'b0;
    rd_req = 1'b0; rd_addr = '0;
    cyc(3);
    chk("rst_busy", busy, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_lag_err", lag_err, 0);

    rst_n = 1'b1;
    cyc(31);
    chk("clear_busy31", busy, 1);
    cyc();
    chk("clear_idle32", busy, 0);

    rd_req = 1'b1; rd_addr = 5'd0;
    cyc();
    chk("idle_rd_ignored", rd_valid, 0);
    rd_req = 1'b0;
    do_start(16'd0);
    chk("idle_len0_ignored", busy, 0);

    // one burst cur=2 lag=3 -> every bin 6
    do_start(16'd1);
    chk("t040_accum", busy, 1);
    send_burst(32, 8'd2, 1'b0, 8'd3);
    wait_done("t040");
    for (int i = 0; i < 32; i++) begin exp_bins[i] = 64'd6; exp20[i] = 64'd6; end
    read_all("t040", 1'b1);
    chk("t040_overflow", overflow, 0);
    chk("t040_lag_err", lag_err, 0);

    // restart from HOLD; a beat during CLEAR must be ignored
    do_start(16'd4);
    chk("t041_clear_busy", busy, 1);
    single_beats(1, 8'd255);
    cyc(31);
    for (int k = 1; k <= 4; k++) begin
      send_burst(32, 8'(k), 1'b1, 8'd0);
      if (k == 3) chk("t041_busy_after3", busy, 1);
    end
    wait_done("t041");
    for (int i = 0; i < 32; i++) exp_bins[i] = 64'(10 * i);
    read_all("t041", 1'b0);
    chk("t041_overflow", overflow, 0);

    // three 1-beat bursts to bin 0 back-to-back
    do_start(16'd3);
    cyc(32);
    single_beats(3, 8'd255);
    wait_done("t042");
    for (int i = 0; i < 32; i++) exp_bins[i] = 64'd0;
    exp_bins[0] = 64'd195075;
    read_all("t042", 1'b0);

    // 17 x 65025 = 1105425; saturates at 1048575 in the 20-bit instance
    do_start(16'd17);
    cyc(32);
    single_beats(17, 8'd255);
    wait_done("t043");
    chk("t043_overflow32", overflow, 0);
    chk("t043_overflow20", overflow20, 1);
    for (int i = 0; i < 32; i++) begin exp_bins[i] = 64'd0; exp20[i] = 64'd0; end
    exp_bins[0] = 64'd1105425;
    exp20[0]    = 64'd1048575;
    read_all("t043", 1'b1);
    chk("t043_overflow20_sticky", overflow20, 1);

    // 34-beat burst: beats 32 and 33 dropped
    do_start(16'd1);
    chk("t044_overflow20_cleared", overflow20, 0);
    cyc(32);
    send_burst(34, 8'd1, 1'b0, 8'd5);
    wait_done("t044");
    chk("t044_lag_err", lag_err, 1);
    for (int i = 0; i < 32; i++) exp_bins[i] = 64'd5;
    read_all("t044", 1'b0);

    // clr mid-burst
    do_start(16'd2);
    chk("t045_lag_err_cleared", lag_err, 0);
    cyc(32);
    for (int i = 0; i < 10; i++) begin
      cur_in = 8'd7; lag_in = 8'd7; lag_first = (i == 0); lag_last = 1'b0; lag_valid = 1'b1;
      cyc();
    end
    lag_valid = 1'b0; lag_first = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    begin
      int n = 0;
      while (busy && n < 100) begin cyc(); n++; end
      chk("t045_clr_busy_cycles", n, 32);
    end
    clr = 1'b1; start = 1'b1; frame_len = 16'd1;
    cyc();
    clr = 1'b0; start = 1'b0;
    cyc(31);
    chk("clr_prio_busy31", busy, 1);
    cyc();
    chk("clr_prio_idle", busy, 0);
    do_start(16'd1);
    send_burst(32, 8'd1, 1'b0, 8'd1);
    wait_done("t045");
    for (int i = 0; i < 32; i++) exp_bins[i] = 64'd1;
    read_all("t045", 1'b0);

    do_start(16'd0);
    chk("hold_len0_ignored", busy, 0);
    rd_req = 1'b1; rd_addr = 5'd3;
    cyc();
    chk("hold_len0_rd_valid", rd_valid, 1);
    chk("hold_len0_rd_data", rd_data, 1);
    rd_req = 1'b0;

    // reset mid-frame
    do_start(16'd1);
    cyc(32);
    for (int i = 0; i < 5; i++) begin
      cur_in = 8'd3; lag_in = 8'd3; lag_first = (i == 0); lag_last = 1'b0; lag_valid = 1'b1;
      cyc();
    end
    lag_valid = 1'b0; lag_first = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("t039_rst_busy", busy, 1);
    chk("t039_rst_rd_valid", rd_valid, 0);
    chk("t039_rst_rd_data", rd_data, 0);
    chk("t039_rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    cyc(32);
    chk("t039_idle", busy, 0);
    do_start(16'd1);
    send_burst(32, 8'd2, 1'b0, 8'd2);
    wait_done("t039");
    for (int i = 0; i < 32; i++) begin exp_bins[i] = 64'd4; exp20[i] = 64'd4; end
    read_all("t039", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_acc8_32.md
CORR_ACC8_32 -- requirements
Module: corr_acc8_32

Interface
REQ-001 SHALL have parameter DW, default 8, sample width in bits.
REQ-002 SHALL have parameter NLAG, default 32, number of lag bins (power of two).
REQ-003 SHALL have parameter AW, default 32, accumulator width in bits.
REQ-004 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: clr  in  1  synchronous abort; accumulators are re-zeroed.
REQ-007 SHALL have port: start  in  1  one-cycle pulse; begins a frame.
REQ-008 SHALL have port: frame_len  in  16  number of bursts per frame; sampled on an accepted start.
REQ-009 SHALL have port: cur_in  in  DW  current sample; stable for the whole burst.
REQ-010 SHALL have port: lag_in  in  DW  delayed sample for the current lag index.
REQ-011 SHALL have port: lag_valid  in  1  lag_in and cur_in valid this cycle.
REQ-012 SHALL have port: lag_first  in  1  qualifies lag_valid; this beat is lag 0 of a burst.
REQ-013 SHALL have port: lag_last  in  1  qualifies lag_valid; this beat is the final beat of a burst.
REQ-014 SHALL have port: rd_req  in  1  readout request.
REQ-015 SHALL have port: rd_addr  in  log2(NLAG)  lag bin to read.
REQ-016 SHALL have ports: rd_data  out  AW, and rd_valid  out  1; the read response.
REQ-017 SHALL have ports: frame_done  out  1 (one-cycle pulse), busy  out  1, overflow  out  1 (sticky), lag_err  out  1 (sticky).

Function
REQ-018 SHALL implement states CLEAR, IDLE, ACCUM, DRAIN and HOLD.
REQ-019 CLEAR SHALL zero bin 0..NLAG-1, one bin per cycle (NLAG cycles), then enter IDLE.
REQ-020 IDLE SHALL, on start with frame_len != 0, latch frame_len, zero the burst count, clear overflow and lag_err, and enter ACCUM; start with frame_len == 0 SHALL be ignored.
REQ-021 ACCUM SHALL accept beats only when lag_valid=1; beats arriving in any other state SHALL be ignored.
REQ-022 Lag index SHALL be 0 on a lag_first beat, and otherwise the previous index +1.
REQ-023 A beat whose index is >= NLAG SHALL be dropped and SHALL set lag_err.
REQ-024 Accumulation SHALL be a 2-stage pipeline: stage 1 registers the unsigned product cur_in*lag_in (2*DW bits) and the index; stage 2 adds the product to bin[index] and writes the result back.
REQ-025 Back-to-back updates to the same bin, including 1-beat bursts, SHALL produce correct sums by forwarding the stage-2 result.
REQ-026 Each add SHALL saturate at 2^AW-1; any saturation SHALL set overflow until the next accepted start or reset.
REQ-027 The burst count SHALL increment on each accepted lag_last beat; lag_first and lag_last may both be set on one beat.
REQ-028 When the burst count reaches frame_len, the state SHALL go ACCUM -> DRAIN, and beats after that lag_last SHALL be ignored.
REQ-029 DRAIN SHALL last 2 cycles, then enter HOLD with frame_done=1 for exactly 1 cycle.
REQ-030 In HOLD, rd_req SHALL cause rd_data=bin[rd_addr] with rd_valid=1 on the next cycle; requests are allowed every cycle.
REQ-031 rd_req outside HOLD SHALL be ignored, with rd_valid=0.
REQ-032 In HOLD, start SHALL enter CLEAR then ACCUM, with frame_len re-latched, and SHALL NOT return to IDLE.
REQ-033 In HOLD, start with frame_len == 0 SHALL be ignored.
REQ-034 clr in any state SHALL discard pipeline contents and enter CLEAR then IDLE; clr SHALL have priority over start.
REQ-035 busy SHALL be 1 in the CLEAR, ACCUM and DRAIN states.

Reset
REQ-036 On reset, state SHALL be CLEAR with the clear pointer at 0 and the pipeline empty.
REQ-037 On reset, rd_data SHALL be 0, and rd_valid, frame_done, overflow and lag_err SHALL be 0.
REQ-038 On reset, busy SHALL be 1.
REQ-039 Reset mid-frame SHALL abandon the frame; all bins SHALL read 0 after the following CLEAR.

Verification
REQ-040 After reset, wait 32 cycles; start with frame_len=1; send one burst of 32 beats with cur=2, lag=3 -> frame_done pulses; every bin reads 6.
REQ-041 frame_len=4; 4 bursts of 32 beats with cur=k and lag_in=index, k=1..4 -> bin[i] reads 10*i, e.g. bin[31]=310.
REQ-042 frame_len=3; three 1-beat bursts (lag_first=lag_last=1) back-to-back with cur=lag=255 -> bin[0]=195075 (forwarding check); all other bins read 0.
REQ-043 AW=20; frame_len=17; 17 single-beat bursts of 255*255 -> bin[0]=1048575 and overflow=1.
REQ-044 Burst of 34 beats -> beats 32 and 33 are dropped, lag_err=1, and bins 0..31 are correct.
REQ-045 Assert clr (or rst_n=0) mid-burst -> busy=1 for 32 cycles, then IDLE; reads in HOLD after a later frame show no residue from the aborted frame.
